lbu_ptr_cmd_seq: RTL

LBU_PTR_CMD_SEQ -- requirements
Module: lbu_ptr_cmd_seq

---
 rtl/lbu_ptr_cmd_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lbu_ptr_cmd_seq.sv
// Line/frame pointer-op sequencer: walks a width x height frame and emits one pointer op per beat.
// Optional serpentine (snake) ordering is compiled in when LBU_SNAKE_EN is defined.
module lbu_ptr_cmd_seq #(
    parameter int unsigned P_MODE       = 3,
    parameter int unsigned P_STRIDE     = 3,
    parameter int unsigned P_DIM        = 8,
    parameter int unsigned P_PTROPNONE  = 0,
    parameter int unsigned P_PTROPRST   = 1,
    parameter int unsigned P_PTROPINCR  = 2,
    parameter int unsigned P_PTROPDECR  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [P_DIM-1:0]    cfg_width,
    input  logic [P_DIM-1:0]    cfg_height,
    input  logic [P_STRIDE-1:0] cfg_stride,
`ifdef LBU_SNAKE_EN
    input  logic                cfg_snake,
`endif
    output logic                op_valid,
    input  logic                op_ready,
    output logic [P_MODE-1:0]   op_code,
    output logic [P_STRIDE-1:0] op_stride,
    output logic                op_eol,
    output logic                op_eof,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [P_DIM-1:0]    r_width;
    logic [P_DIM-1:0]    r_height;
    logic [P_DIM-1:0]    r_col;
    logic [P_DIM-1:0]    r_row;
    logic [P_STRIDE-1:0] r_stride;
    logic                w_snake;
    logic                w_empty;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_xfer;
    logic                w_start;
    logic [P_MODE-1:0]   w_code;

`ifdef LBU_SNAKE_EN
    logic r_snake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snake <= 1'b0;
        end else if (w_start) begin
            r_snake <= cfg_snake;
        end
    end

    assign w_snake = r_snake;
`else
    assign w_snake = 1'b0;
`endif

    // Empty frames still pass through ISSUE for one cycle so busy/done behave uniformly.
    assign w_empty    = (r_width == '0) || (r_height == '0);
    assign w_last_col = (r_col == r_width - P_DIM'(1));
    assign w_last_row = (r_row == r_height - P_DIM'(1));
    assign w_start    = (r_state == ST_IDLE) && start && !abort;

    assign op_valid  = (r_state == ST_ISSUE) && !w_empty;
    assign w_xfer    = op_valid && op_ready;
    assign op_eol    = op_valid && w_last_col;
    assign op_eof    = op_eol && w_last_row;
    assign op_code   = op_valid ? w_code : '0;
    assign op_stride = op_valid ? r_stride : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    always_comb begin
        w_code = P_MODE'(P_PTROPINCR);
        if (r_col == '0) begin
            w_code = (w_snake && (r_row != '0)) ? P_MODE'(P_PTROPNONE) : P_MODE'(P_PTROPRST);
        end else if (w_snake && r_row[0]) begin
            w_code = P_MODE'(P_PTROPDECR);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_empty || (w_xfer && op_eof)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        // Abort overrides start, a pending transfer and the DONE handoff.
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width  <= '0;
            r_height <= '0;
            r_stride <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_start) begin
            r_width  <= cfg_width;
            r_height <= cfg_height;
            r_stride <= cfg_stride;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_xfer && !abort) begin
            if (w_last_col) begin
                r_col <= '0;
                // Row holds on the eof beat so it never runs past height-1.
                if (!w_last_row) r_row <= r_row + P_DIM'(1);
            end else begin
                r_col <= r_col + P_DIM'(1);
            end
        end
    end

endmodule
